// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: combinational ROM port, redirect inputs and the decode valid/ready handshake.
// master = fetch unit, slave = ROM/decode/redirect side.
interface if_fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            rom_ce;
    logic [XLEN-1:0] rom_addr;
    logic [XLEN-1:0] rom_inst;
    logic            flush;
    logic [XLEN-1:0] new_pc;
    logic            br_valid;
    logic [XLEN-1:0] br_target;
    logic            id_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_inst;

    modport master (
        output rom_ce, rom_addr,
        input  rom_inst,
        input  flush, new_pc, br_valid, br_target,
        input  id_ready,
        output id_valid, id_pc, id_inst
    );

    modport slave (
        input  rom_ce, rom_addr,
        output rom_inst,
        output flush, new_pc, br_valid, br_target,
        output id_ready,
        input  id_valid, id_pc, id_inst
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational ROM and hands {pc,inst} to decode.
// Optional prefetch FIFO between ROM and decode is enabled by defining IF_PREFETCH_BUF_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input logic             clk,
    input logic             rst,
    if_fetch_unit_if.master bus
);
    localparam int unsigned     XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:2], 2'b00};

    typedef enum logic {S_BOOT, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            run;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch;
    logic [3:0]      unused_low_bits;

    assign run      = (state_q == S_RUN);
    assign redirect = bus.flush | bus.br_valid;

    // Flush outranks branch; targets are forced word aligned.
    assign redirect_pc = bus.flush ? {bus.new_pc[XLEN-1:2], 2'b00}
                                   : {bus.br_target[XLEN-1:2], 2'b00};
    assign unused_low_bits = {bus.new_pc[1:0], bus.br_target[1:0]};

    assign bus.rom_addr = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= PC_INIT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Boot spends exactly one dead cycle; redirects still load the PC there.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (fetch) begin
            pc_d = pc_q + PC_STEP;
        end
    end

`ifndef IF_PREFETCH_BUF_EN
    localparam int unsigned UNUSED_QDEPTH = QDEPTH;

    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_inst_q, id_inst_d;
    logic            slot_free;

    assign slot_free  = !id_valid_q | bus.id_ready;
    assign fetch      = run & slot_free & !redirect;
    assign bus.rom_ce = run;

    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        if (redirect) begin
            id_valid_d = 1'b0;
        end else if (fetch) begin
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_inst_d  = bus.rom_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    assign bus.id_valid = id_valid_q;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_inst  = id_inst_q;
`else
    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic [XLEN-1:0]  q_pc   [QDEPTH];
    logic [XLEN-1:0]  q_inst [QDEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Full is judged before this cycle's pop, so a pop never frees room for a same-cycle push.
    assign full       = (count_q == CNT_W'(QDEPTH));
    assign empty      = (count_q == '0);
    assign fetch      = run & !full & !redirect;
    assign push       = fetch;
    assign pop        = !empty & bus.id_ready & !redirect;
    assign bus.rom_ce = run & !full;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                q_pc[wr_ptr_q]   <= pc_q;
                q_inst[wr_ptr_q] <= bus.rom_inst;
            end
        end
    end

    assign bus.id_valid = !empty;
    assign bus.id_pc    = q_pc[rd_ptr_q];
    assign bus.id_inst  = q_inst[rd_ptr_q];
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a stream model predicts the {pc,inst} order decode accepts;
// directed sections pin reset, boot cycle, latency, stall, redirect and PC wrap timing.
module tb_if_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_unit_if bus ();
    if_fetch_unit_if bus2 ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int checks_total  = 0;
    int checks_passed = 0;
    int accepts       = 0;

    // ROM word i holds 32'h1000_0000 + i
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    always_comb bus.rom_inst  = bus.rom_ce  ? rom_word(bus.rom_addr)  : 32'h0;
    always_comb bus2.rom_inst = bus2.rom_ce ? rom_word(bus2.rom_addr) : 32'h0;
    assign bus2.flush     = 1'b0;
    assign bus2.new_pc    = 32'h0;
    assign bus2.br_valid  = 1'b0;
    assign bus2.br_target = 32'h0;
    assign bus2.id_ready  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Stream model: decode sees consecutive words from the last restart point.
    logic [63:0] exp_q[$];
    logic [31:0] model_pc;

    function automatic void model_topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back({model_pc, rom_word(model_pc)});
            model_pc = model_pc + 32'd4;
        end
    endfunction

    function automatic void model_restart(input logic [31:0] target);
        exp_q.delete();
        model_pc = {target[31:2], 2'b00};
        model_topup();
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        model_topup();
    endtask

    // Monitor: pops on every real handshake and checks the stable-hold rule.
    initial begin
        logic        hold_prev;
        logic [31:0] hold_pc;
        logic [31:0] hold_inst;
        logic        redir;
        logic [63:0] e;
        hold_prev = 1'b0;
        hold_pc   = '0;
        hold_inst = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                redir = bus.flush | bus.br_valid;
                if (hold_prev) begin
                    check("hold_valid", 32'(bus.id_valid), 32'd1);
                    check("hold_pc", bus.id_pc, hold_pc);
                    check("hold_inst", bus.id_inst, hold_inst);
                end
                if (bus.id_valid && bus.id_ready && !redir) begin
                    check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_pc", bus.id_pc, e[63:32]);
                        check("sb_inst", bus.id_inst, e[31:0]);
                    end
                    accepts++;
                end
                hold_prev = bus.id_valid & !bus.id_ready & !redir;
                hold_pc   = bus.id_pc;
                hold_inst = bus.id_inst;
            end
        end
    end

    // Wrap instance: FFFF_FFF8, FFFF_FFFC, 0000_0000 back to back.
    initial begin
        int waited;
        waited = 0;
        @(posedge clk);
        #1;
        while ((rst !== 1'b0 || bus2.id_valid !== 1'b1) && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("wrap_start_seen", 32'(bus2.id_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("wrap_valid", 32'(bus2.id_valid), 32'd1);
            check("wrap_pc", bus2.id_pc, 32'hFFFF_FFF8 + 32'(4 * k));
            check("wrap_inst", bus2.id_inst, rom_word(32'hFFFF_FFF8 + 32'(4 * k)));
            @(posedge clk);
            #1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst = 1'b1;
        bus.flush = 1'b0; bus.new_pc = '0; bus.br_valid = 1'b0; bus.br_target = '0;
        bus.id_ready = 1'b1;
        model_restart(32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_id_valid", 32'(bus.id_valid), 32'd0);
        check("rst_id_pc", bus.id_pc, 32'd0);
        check("rst_id_inst", bus.id_inst, 32'd0);
        check("rst_rom_ce", 32'(bus.rom_ce), 32'd0);
        rst = 1'b0;
        check("boot_rom_ce", 32'(bus.rom_ce), 32'd0);
        cycle();
        check("run_rom_ce", 32'(bus.rom_ce), 32'd1);
        check("run_addr", bus.rom_addr, 32'd0);
        check("run_first_valid", 32'(bus.id_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("seq_valid", 32'(bus.id_valid), 32'd1);
            check("seq_pc", bus.id_pc, 32'(4 * k));
            check("seq_inst", bus.id_inst, 32'h1000_0000 + 32'(k));
        end
`ifndef IF_PREFETCH_BUF_EN
        bus.id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_pc", bus.id_pc, 32'd8);
            check("stall_inst", bus.id_inst, 32'h1000_0002);
            check("stall_addr", bus.rom_addr, 32'd12);
        end
        bus.id_ready = 1'b1;
        cycle();
        check("release_pc", bus.id_pc, 32'd12);
        check("release_inst", bus.id_inst, 32'h1000_0003);
        cycle();
        check("pc16", bus.id_pc, 32'd16);
        bus.id_ready = 1'b0;
        cycle();
        check("pc16_held", bus.id_pc, 32'd16);
        bus.br_valid = 1'b1; bus.br_target = 32'h0000_0102;
        model_restart(bus.br_target);
        cycle();
        bus.br_valid = 1'b0;
        check("br_kill_valid", 32'(bus.id_valid), 32'd0);
        check("br_addr", bus.rom_addr, 32'h100);
        cycle();
        check("br_valid_out", 32'(bus.id_valid), 32'd1);
        check("br_pc", bus.id_pc, 32'h100);
        bus.flush = 1'b1; bus.new_pc = 32'h380;
        bus.br_valid = 1'b1; bus.br_target = 32'h200;
        model_restart(bus.new_pc);
        cycle();
        bus.flush = 1'b0; bus.br_valid = 1'b0;
        check("flush_kill_valid", 32'(bus.id_valid), 32'd0);
        check("flush_addr", bus.rom_addr, 32'h380);
        cycle();
        check("flush_pc", bus.id_pc, 32'h380);
        check("flush_inst", bus.id_inst, rom_word(32'h380));
        bus.id_ready = 1'b1;
`else
        bus.id_ready = 1'b0;
        rst = 1'b1;
        model_restart(32'h0);
        cycle();
        rst = 1'b0;
        cycle();
        check("pf_run_addr", bus.rom_addr, 32'd0);
        cycle();
        check("pf_one_pc", bus.id_pc, 32'd0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("pf_full_ce", 32'(bus.rom_ce), 32'd0);
            check("pf_full_addr", bus.rom_addr, 32'd8);
            check("pf_full_pc", bus.id_pc, 32'd0);
        end
        bus.id_ready = 1'b1;
        cycle();
        check("pf_drain_pc4", bus.id_pc, 32'd4);
        check("pf_drain_addr", bus.rom_addr, 32'd8);
        cycle();
        check("pf_drain_pc8", bus.id_pc, 32'd8);
        bus.id_ready = 1'b0;
        cycle();
        check("pf_refull_ce", 32'(bus.rom_ce), 32'd0);
        bus.br_valid = 1'b1; bus.br_target = 32'h40;
        model_restart(bus.br_target);
        cycle();
        bus.br_valid = 1'b0;
        check("pf_br_empty", 32'(bus.id_valid), 32'd0);
        check("pf_br_addr", bus.rom_addr, 32'h40);
        cycle();
        check("pf_br_pc", bus.id_pc, 32'h40);
        bus.id_ready = 1'b1;
`endif
        repeat (3) cycle();
        check("mid_valid", 32'(bus.id_valid), 32'd1);
        rst = 1'b1;
        model_restart(32'h0);
        #1;
        check("async_rst_valid", 32'(bus.id_valid), 32'd0);
        check("async_rst_ce", 32'(bus.rom_ce), 32'd0);
        check("async_rst_pc", bus.id_pc, 32'd0);
        cycle();
        rst = 1'b0;
        check("rerst_boot_ce", 32'(bus.rom_ce), 32'd0);
        cycle();
        check("rerst_addr", bus.rom_addr, 32'd0);
        cycle();
        check("rerst_pc", bus.id_pc, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            cycle();
            bus.flush = 1'b0;
            bus.br_valid = 1'b0;
            if (rst) begin
                rst = 1'b0;
                continue;
            end
            bus.id_ready = ($urandom_range(3) != 0);
            r = int'($urandom_range(199));
            if (r < 8) begin
                bus.flush = 1'b1;
                bus.new_pc = $urandom;
                bus.br_valid = 1'($urandom_range(1));
                bus.br_target = $urandom;
                model_restart(bus.new_pc);
            end else if (r < 18) begin
                bus.br_valid = 1'b1;
                bus.br_target = $urandom;
                model_restart(bus.br_target);
            end else if (r == 199) begin
                rst = 1'b1;
                model_restart(32'h0);
            end
        end
        bus.flush = 1'b0; bus.br_valid = 1'b0; rst = 1'b0; bus.id_ready = 1'b1;
        repeat (5) cycle();
        check("random_progress", 32'(accepts > 600), 32'd1);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
